// File: rtl/vertex_primitive_backend.sv
// vertex_primitive_backend
//   Back half of the transform pipeline. Clip-space vertices are perspective
//   divided and viewport mapped into an internal vertex store. Index triples
//   are then read, assembled from the store, culled (invalid / out-of-range /
//   back-facing or degenerate) and passed to the rasterizer over valid/ready.
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   start / o_ready / o_done       batch control (o_ready high in IDLE)
//   i_vertex[3:0] (x,y,z,w)        clip-space vertex, i_vertex_dv/_last, o_vertex_ready
//   o_index_read_en, i_index[2:0]  index triple request / data, i_index_dv/_last
//   o_v0/o_v1/o_v2 [2:0]           triangle vertices {z,y,x} ([0]=x)
//   o_dv, i_ready, o_last          triangle handshake, final-triple strobe
module vertex_primitive_backend #(
    parameter int IV_DATAWIDTH     = 24,
    parameter int IV_FRACBITS      = 13,
    parameter int OV_DATAWIDTH     = 12,
    parameter int SCREEN_WIDTH     = 320,
    parameter int SCREEN_HEIGHT    = 320,
    parameter int MAX_VERTEX_COUNT = 4096,
    localparam int AW = $clog2(MAX_VERTEX_COUNT)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    output logic                              o_ready,
    output logic                              o_done,
    input  logic [3:0][IV_DATAWIDTH-1:0]      i_vertex,
    input  logic                              i_vertex_dv,
    input  logic                              i_vertex_last,
    output logic                              o_vertex_ready,
    output logic                              o_index_read_en,
    input  logic [2:0][AW-1:0]                i_index,
    input  logic                              i_index_dv,
    input  logic                              i_index_last,
    output logic [2:0][OV_DATAWIDTH-1:0]      o_v0,
    output logic [2:0][OV_DATAWIDTH-1:0]      o_v1,
    output logic [2:0][OV_DATAWIDTH-1:0]      o_v2,
    output logic                              o_dv,
    input  logic                              i_ready,
    output logic                              o_last
);
    localparam int IW  = IV_DATAWIDTH;
    localparam int F   = IV_FRACBITS;
    localparam int OW  = OV_DATAWIDTH;
    localparam int N   = IW + F;          // dividend bits: |c| << F
    localparam int PW  = N + 18;          // viewport products never overflow
    localparam int EW  = 3 * OW + 1;      // {inv, z, y, x}
    localparam int SW  = $clog2(N + 1);
    localparam int AWD = 2 * OW + 2;
    localparam logic [AW:0]           MAXC = (AW+1)'(MAX_VERTEX_COUNT);
    localparam logic signed [PW-1:0]  ONE  = PW'(2**F);
    localparam logic signed [PW-1:0]  WS   = PW'(SCREEN_WIDTH);
    localparam logic signed [PW-1:0]  HS   = PW'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_VERTEX, S_PRIM, S_DONE} state_e;
    typedef enum logic [1:0] {T_IDLE, T_READ, T_OUT} tph_e;

    state_e state_q, state_d;
    tph_e   tph_q;

    // ---------------- vertex path: 3 parallel restoring dividers ----------------
    logic              vbusy_q, vfin_q, vlast_q, vinv_q;
    logic [SW-1:0]     step_q;
    logic [IW-1:0]     div_q;
    logic [2:0]        neg_q;
    logic [2:0][N-1:0] sh_q;     // dividend shifts out the top, quotient in the bottom
    logic [2:0][IW-1:0] rem_q;
    logic [AW:0]       vcnt_q;
    logic [EW-1:0]     mem [MAX_VERTEX_COUNT];

    logic              vacc, in_inv;
    logic signed [IW-1:0] vx, vy, vz, vw;
    logic [2:0][IW-1:0] mag, rsub;
    logic [2:0][IW:0]  trial, diff;
    logic [2:0]        ge;
    logic signed [PW-1:0] n [3];
    logic signed [PW-1:0] px_raw, py_raw, pz_raw;
    logic [EW-1:0]     wdata;

    assign vacc = o_vertex_ready & i_vertex_dv;
    assign vx = $signed(i_vertex[0]);
    assign vy = $signed(i_vertex[1]);
    assign vz = $signed(i_vertex[2]);
    assign vw = $signed(i_vertex[3]);
    // w > 0 is established first, so -vw cannot overflow where it matters
    assign in_inv = vw[IW-1] || (vw == '0) || (vx > vw) || (vx < -vw) ||
                    (vy > vw) || (vy < -vw) || vz[IW-1] || (vz > vw);

    function automatic logic [OW-1:0] clampv(input logic signed [PW-1:0] v,
                                             input logic signed [PW-1:0] hi);
        if (v[PW-1])  return '0;
        if (v > hi)   return OW'(hi);
        return OW'(v);
    endfunction

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            mag[c]   = i_vertex[c][IW-1] ? (~i_vertex[c] + 1'b1) : i_vertex[c];
            trial[c] = {rem_q[c], sh_q[c][N-1]};
            diff[c]  = trial[c] - {1'b0, div_q};
            ge[c]    = trial[c] >= {1'b0, div_q};
            rsub[c]  = ge[c] ? diff[c][IW-1:0] : trial[c][IW-1:0];
            n[c]     = neg_q[c] ? -$signed({{(PW-N){1'b0}}, sh_q[c]})
                                :  $signed({{(PW-N){1'b0}}, sh_q[c]});
        end
        px_raw = ((n[0] + ONE) * WS) >>> (F + 1);
        py_raw = ((ONE - n[1]) * HS) >>> (F + 1);
        pz_raw = n[2] >>> (F - 12);
        wdata  = {vinv_q, clampv(pz_raw, PW'(4095)),
                  clampv(py_raw, HS - PW'(1)), clampv(px_raw, WS - PW'(1))};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vbusy_q <= 1'b0; vfin_q <= 1'b0; vlast_q <= 1'b0; vinv_q <= 1'b0;
            step_q  <= '0;   div_q  <= '0;   vcnt_q  <= '0;
            neg_q   <= '0;   sh_q   <= '0;   rem_q   <= '0;
        end else begin
            if (state_q == S_IDLE && start) vcnt_q <= '0;
            if (vacc) begin
                vbusy_q <= 1'b1;
                vfin_q  <= 1'b0;
                step_q  <= '0;
                vlast_q <= i_vertex_last;
                vinv_q  <= in_inv;
                div_q   <= i_vertex[3];
                for (int c = 0; c < 3; c++) begin
                    neg_q[c] <= i_vertex[c][IW-1];
                    sh_q[c]  <= {mag[c], {F{1'b0}}};
                    rem_q[c] <= '0;
                end
            end else if (vbusy_q && !vfin_q) begin
                step_q <= step_q + 1'b1;
                if (step_q == SW'(N - 1)) vfin_q <= 1'b1;
                for (int c = 0; c < 3; c++) begin
                    rem_q[c] <= rsub[c];
                    sh_q[c]  <= {sh_q[c][N-2:0], ge[c]};
                end
            end else if (vfin_q) begin
                // write cycle; vertices beyond the store depth are dropped
                vbusy_q <= 1'b0;
                vfin_q  <= 1'b0;
                if (vcnt_q < MAXC) vcnt_q <= vcnt_q + 1'b1;
            end
        end
    end

    // ---------------- vertex store: 1 write, 3 registered reads ----------------
    logic          tacc;
    logic [EW-1:0] rd_q [3];

    assign tacc = o_index_read_en & i_index_dv;

    always_ff @(posedge clk) begin
        if (vfin_q && vcnt_q < MAXC) mem[vcnt_q[AW-1:0]] <= wdata;
        if (tacc) for (int k = 0; k < 3; k++) rd_q[k] <= mem[i_index[k]];
    end

    // ---------------- primitive assembly / cull ----------------
    logic                         oob_q, tlast_q, past_q, dv_q, lastc_q, cull;
    logic [2:0][2:0][OW-1:0]      ov_q;
    logic signed [AWD-1:0]        xs [3], ys [3], area;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            xs[k] = AWD'($signed(rd_q[k][OW-1:0]));
            ys[k] = AWD'($signed(rd_q[k][2*OW-1:OW]));
        end
        area = (xs[1] - xs[0]) * (ys[2] - ys[0]) - (xs[2] - xs[0]) * (ys[1] - ys[0]);
        cull = oob_q || rd_q[0][EW-1] || rd_q[1][EW-1] || rd_q[2][EW-1] ||
               area[AWD-1] || (area == '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tph_q <= T_IDLE; oob_q <= 1'b0; tlast_q <= 1'b0; past_q <= 1'b0;
            dv_q  <= 1'b0;   lastc_q <= 1'b0; ov_q <= '0;
        end else begin
            lastc_q <= 1'b0;
            if (state_q == S_IDLE) past_q <= 1'b0;
            case (tph_q)
                T_IDLE: if (tacc) begin
                    oob_q   <= ({1'b0, i_index[0]} >= vcnt_q) || ({1'b0, i_index[1]} >= vcnt_q) ||
                               ({1'b0, i_index[2]} >= vcnt_q);
                    tlast_q <= i_index_last;
                    past_q  <= i_index_last;
                    tph_q   <= T_READ;
                end
                T_READ: if (cull) begin
                    lastc_q <= tlast_q;   // culled final triple still strobes o_last
                    tph_q   <= T_IDLE;
                end else begin
                    for (int k = 0; k < 3; k++) ov_q[k] <= rd_q[k][3*OW-1:0];
                    dv_q  <= 1'b1;
                    tph_q <= T_OUT;
                end
                T_OUT: if (i_ready) begin
                    dv_q  <= 1'b0;
                    tph_q <= T_IDLE;
                end
                default: tph_q <= T_IDLE;
            endcase
        end
    end

    assign o_dv   = dv_q;
    assign o_v0   = ov_q[0];
    assign o_v1   = ov_q[1];
    assign o_v2   = ov_q[2];
    assign o_last = lastc_q | (dv_q & i_ready & tlast_q);

    // ---------------- batch FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        o_ready         = 1'b0;
        o_done          = 1'b0;
        o_vertex_ready  = 1'b0;
        o_index_read_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (start) state_d = S_VERTEX;
            end
            S_VERTEX: begin
                o_vertex_ready = !vbusy_q;
                if (vfin_q && vlast_q) state_d = S_PRIM;
            end
            S_PRIM: begin
                o_index_read_en = (tph_q == T_IDLE) && !past_q;
                if (o_last) state_d = S_DONE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_vertex_primitive_backend.sv
module tb_vertex_primitive_backend;
    localparam int AW = 12;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic                 o_ready, o_done, o_vertex_ready, o_index_read_en;
    logic [3:0][23:0]     i_vertex = '0;
    logic                 i_vertex_dv = 1'b0, i_vertex_last = 1'b0;
    logic [2:0][AW-1:0]   i_index = '0;
    logic                 i_index_dv = 1'b0, i_index_last = 1'b0;
    logic [2:0][11:0]     o_v0, o_v1, o_v2;
    logic                 o_dv, o_last;
    logic                 i_ready = 1'b1;

    vertex_primitive_backend dut (
        .clk(clk), .rstn(rstn), .start(start), .o_ready(o_ready), .o_done(o_done),
        .i_vertex(i_vertex), .i_vertex_dv(i_vertex_dv), .i_vertex_last(i_vertex_last),
        .o_vertex_ready(o_vertex_ready), .o_index_read_en(o_index_read_en),
        .i_index(i_index), .i_index_dv(i_index_dv), .i_index_last(i_index_last),
        .o_v0(o_v0), .o_v1(o_v1), .o_v2(o_v2), .o_dv(o_dv), .i_ready(i_ready),
        .o_last(o_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dv;
        logic        last;
        logic [35:0] v0, v1, v2;
    } exp_t;

    exp_t        sbq[$];
    int          nvec = 0, nerr = 0;
    int          mcnt = 0;
    logic [35:0] ment [64];
    bit          minv [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference: truncating divide then viewport map and clamp
    task automatic model_vtx(input int x, input int y, input int z, input int w,
                             output logic [35:0] e, output bit inv);
        longint nx, ny, nz, px, py, pz;
        inv = (w <= 0) || (x > w) || (x < -w) || (y > w) || (y < -w) || (z < 0) || (z > w);
        e = '0;
        if (!inv) begin
            nx = (longint'(x) * 8192) / w;
            ny = (longint'(y) * 8192) / w;
            nz = (longint'(z) * 8192) / w;
            px = ((nx + 8192) * 320) / 16384;
            py = ((8192 - ny) * 320) / 16384;
            pz = nz / 2;
            if (px > 319) px = 319;
            if (px < 0) px = 0;
            if (py > 319) py = 319;
            if (py < 0) py = 0;
            if (pz > 4095) pz = 4095;
            e = {12'(pz), 12'(py), 12'(px)};
        end
    endtask

    task automatic send_vtx(input int x, input int y, input int z, input int w, input bit last);
        int n = 0;
        logic [35:0] e;
        bit inv;
        while (!o_vertex_ready && n < 200) begin tick(); n++; end
        if (n >= 200) chk("to_vertex_ready", 64'(0), 64'(1));
        model_vtx(x, y, z, w, e, inv);
        if (mcnt < 64) begin ment[mcnt] = e; minv[mcnt] = inv; end
        mcnt++;
        i_vertex[0] = 24'(x); i_vertex[1] = 24'(y);
        i_vertex[2] = 24'(z); i_vertex[3] = 24'(w);
        i_vertex_last = last;
        i_vertex_dv = 1'b1;
        tick();
        i_vertex_dv = 1'b0;
        i_vertex_last = 1'b0;
    endtask

    task automatic send_tri(input int a, input int b, input int c, input bit last);
        int n = 0;
        bit cull;
        int x0, y0, x1, y1, x2, y2, area;
        exp_t e;
        while (!o_index_read_en && n < 200) begin tick(); n++; end
        if (n >= 200) chk("to_index_read_en", 64'(0), 64'(1));
        cull = (a >= mcnt) || (b >= mcnt) || (c >= mcnt);
        if (!cull) begin
            cull = minv[a] || minv[b] || minv[c];
            x0 = int'(ment[a][11:0]); y0 = int'(ment[a][23:12]);
            x1 = int'(ment[b][11:0]); y1 = int'(ment[b][23:12]);
            x2 = int'(ment[c][11:0]); y2 = int'(ment[c][23:12]);
            area = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
            if (area <= 0) cull = 1'b1;
        end
        if (!cull) begin
            e.dv = 1'b1; e.last = last; e.v0 = ment[a]; e.v1 = ment[b]; e.v2 = ment[c];
            sbq.push_back(e);
        end else if (last) begin
            e = '0; e.last = 1'b1;
            sbq.push_back(e);
        end
        i_index[0] = AW'(a); i_index[1] = AW'(b); i_index[2] = AW'(c);
        i_index_last = last;
        i_index_dv = 1'b1;
        tick();
        i_index_dv = 1'b0;
        i_index_last = 1'b0;
    endtask

    task automatic start_batch;
        mcnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_low_after_start", 64'(o_ready), 64'(0));
    endtask

    task automatic finish_batch;
        int n = 0;
        while (!o_last && n < 300) begin tick(); n++; end
        if (n >= 300) chk("to_last", 64'(0), 64'(1));
        tick();
        chk("done_pulse", 64'(o_done), 64'(1));
        tick();
        chk("done_clear", 64'(o_done), 64'(0));
        chk("ready_back", 64'(o_ready), 64'(1));
    endtask

    // output monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (o_dv && !i_ready) begin
                    if (sbq.size() == 0) chk("stall_unexpected", 64'(1), 64'(0));
                    else begin
                        chk("stall_v0", 64'(o_v0), 64'(sbq[0].v0));
                        chk("stall_v1", 64'(o_v1), 64'(sbq[0].v1));
                        chk("stall_v2", 64'(o_v2), 64'(sbq[0].v2));
                    end
                end
                if (o_last || (o_dv && i_ready)) begin
                    if (sbq.size() == 0) chk("unexpected_out", 64'(1), 64'(0));
                    else begin
                        e = sbq.pop_front();
                        chk("tri_dv", 64'(o_dv), 64'(e.dv));
                        chk("tri_last", 64'(o_last), 64'(e.last));
                        if (e.dv) begin
                            chk("tri_v0", 64'(o_v0), 64'(e.v0));
                            chk("tri_v1", 64'(o_v1), 64'(e.v1));
                            chk("tri_v2", 64'(o_v2), 64'(e.v2));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   64'(o_ready), 64'(1));
        chk({tag, "_done"},    64'(o_done), 64'(0));
        chk({tag, "_vready"},  64'(o_vertex_ready), 64'(0));
        chk({tag, "_rden"},    64'(o_index_read_en), 64'(0));
        chk({tag, "_dv"},      64'(o_dv), 64'(0));
        chk({tag, "_last"},    64'(o_last), 64'(0));
        chk({tag, "_v"},       64'({o_v0, o_v1, o_v2}), 64'(0));
    endtask

    initial begin
        int n;
        int w, x, y, z;
        repeat (3) tick();
        check_reset_outputs("rst");
        rstn = 1'b1;
        tick();
        chk("idle_ready", 64'(o_ready), 64'(1));

        // batch A: mapping, clamp, invalid vertex, winding, stall, culled final triple
        start_batch();
        send_vtx(0, 0, 4096, 8192, 0);          // (160,160,2048)
        send_vtx(8192, -8192, 0, 8192, 0);      // (319,319,0) clamped
        send_vtx(100, 100, 100, 0, 0);          // w = 0 -> invalid
        send_vtx(-8192, 8192, 0, 8192, 0);      // (0,0)
        send_vtx(-3072, 8192, 0, 8192, 0);      // (100,0)
        send_vtx(-8192, 3072, 0, 8192, 1);      // (0,100)
        i_ready = 1'b0;
        send_tri(3, 4, 5, 0);
        n = 0;
        while (!o_dv && n < 10) begin tick(); n++; end
        if (n >= 10) chk("to_dv", 64'(0), 64'(1));
        repeat (10) tick();
        i_ready = 1'b1;
        tick();
        chk("single_handshake", 64'(o_dv), 64'(0));
        send_tri(3, 5, 4, 0);                   // wrong winding
        send_tri(0, 4, 1, 0);                   // carries both mapped test vertices
        send_tri(3, 4, 9, 0);                   // index out of range
        send_tri(0, 1, 2, 1);                   // invalid vertex, final: o_last alone
        finish_batch();

        // batch B: random vertices and triples
        start_batch();
        for (int i = 0; i < 8; i++) begin
            w = int'($urandom_range(20000, 1000));
            x = int'($urandom_range(2 * w, 0)) - w;
            y = int'($urandom_range(2 * w, 0)) - w;
            z = (i % 4 == 3) ? -5 : int'($urandom_range(w, 0));
            send_vtx(x, y, z, w, i == 7);
        end
        for (int j = 0; j < 10; j++)
            send_tri(int'($urandom_range(8, 0)), int'($urandom_range(8, 0)),
                     int'($urandom_range(8, 0)), j == 9);
        finish_batch();

        // batch C: 3 vertices, 2 triples, start to end
        start_batch();
        send_vtx(-8192, 8192, 0, 8192, 0);
        send_vtx(-3072, 8192, 0, 8192, 0);
        send_vtx(-8192, 3072, 0, 8192, 1);
        send_tri(0, 2, 1, 0);
        send_tri(0, 1, 2, 1);
        finish_batch();

        // batch D: reset in the middle of VERTEX
        start_batch();
        send_vtx(0, 0, 4096, 8192, 0);
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rstn = 1'b1;
        tick();

        // batch E: recovery after reset
        start_batch();
        send_vtx(-8192, 8192, 4096, 8192, 0);
        send_vtx(-3072, 8192, 8192, 8192, 0);
        send_vtx(-8192, 3072, 2048, 8192, 1);
        send_tri(0, 1, 2, 1);
        finish_batch();

        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
